// File: rtl/anton_neopixel_apb_bridge.sv
// APB slave bridge onto the byte-wide neopixel buffer/register port.
// One transfer at a time: latch on setup, single-cycle strobe, optional read capture, one-cycle response.
module anton_neopixel_apb_bridge #(
   parameter int ADDR_W = 16
) (
   input  logic              busClk,
   input  logic              busResetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic [13:0]       busAddr,
   output logic [7:0]        busDataIn,
   output logic              busWrite,
   output logic              busRead,
   input  logic [7:0]        busDataOut
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STROBE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   state_t state_r;
   logic   write_r;
   logic   err_r;
   logic   setup_err_s;
   logic   unused_pwdata_s;

   // Misaligned accesses fail, and so do writes to the read-only status register.
   function automatic logic addr_err(input logic [15:0] addr, input logic is_write);
      return (addr[1:0] != 2'b00) || (is_write && addr[15] && (addr[3:2] == 2'b11));
   endfunction

   assign setup_err_s     = addr_err(paddr[15:0], pwrite);
   assign unused_pwdata_s = ^pwdata[31:8];

   // Transfer sequencer; every output is registered on entry to the state that owns it.
   always_ff @(posedge busClk) begin
      if (!busResetn) begin
         state_r   <= ST_IDLE;
         write_r   <= 1'b0;
         err_r     <= 1'b0;
         prdata    <= 32'h0000_0000;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         busAddr   <= 14'd0;
         busDataIn <= 8'h00;
         busWrite  <= 1'b0;
         busRead   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               pready  <= 1'b0;
               pslverr <= 1'b0;
               if (psel && !penable) begin
                  busAddr   <= paddr[15:2];
                  busDataIn <= pwdata[7:0];
                  write_r   <= pwrite;
                  err_r     <= setup_err_s;
                  busWrite  <= pwrite && !setup_err_s;
                  busRead   <= !pwrite && !setup_err_s;
                  state_r   <= ST_STROBE;
               end else begin
                  busWrite <= 1'b0;
                  busRead  <= 1'b0;
                  state_r  <= ST_IDLE;
               end
            end
            ST_STROBE: begin
               busWrite <= 1'b0;
               busRead  <= 1'b0;
               if (!psel) begin
                  state_r <= ST_IDLE;
               end else if (!write_r && !err_r) begin
                  state_r <= ST_CAPTURE;
               end else begin
                  pready  <= 1'b1;
                  pslverr <= err_r;
                  state_r <= ST_RESP;
               end
            end
            // An abandoned read does not count as successful, so prdata is left alone.
            ST_CAPTURE: begin
               if (!psel) begin
                  state_r <= ST_IDLE;
               end else begin
                  prdata  <= {24'h00_0000, busDataOut};
                  pready  <= 1'b1;
                  pslverr <= 1'b0;
                  state_r <= ST_RESP;
               end
            end
            ST_RESP: begin
               pready  <= 1'b0;
               pslverr <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               pready   <= 1'b0;
               pslverr  <= 1'b0;
               busWrite <= 1'b0;
               busRead  <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/anton_neopixel_apb_bridge.md
ANTON_NEOPIXEL_APB_BRIDGE -- requirements
Module: anton_neopixel_apb_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning APB byte-address width; busAddr = paddr[15:2].
REQ-002 SHALL have ports:
- busClk  input  1  single clock; all logic on rising edge.
- busResetn  input  1  reset, synchronous, active-low.
- psel  input  1  APB select.
- penable  input  1  APB access phase.
- pwrite  input  1  1=write, 0=read.
- paddr  input  ADDR_W  APB byte address.
- pwdata  input  32  write data; only [7:0] used.
- prdata  output  32  read data, {24'b0, byte}.
- pready  output  1  transfer complete.
- pslverr  output  1  transfer error, valid with pready.
- busAddr  output  14  neopixel word address.
- busDataIn  output  8  neopixel write byte.
- busWrite  output  1  one-cycle write strobe.
- busRead  output  1  one-cycle read strobe.
- busDataOut  input  8  neopixel read byte, valid the cycle after busRead.
REQ-003 SHALL use one clock; reset is synchronous and active-low, sampled on the rising edge of busClk.

Function
REQ-004 SHALL implement FSM states IDLE, STROBE, CAPTURE, RESP.
REQ-005 IDLE: on psel=1 and penable=0 (setup), SHALL latch paddr[15:2] into busAddr, pwdata[7:0] into busDataIn, pwrite and error flag; next state STROBE.
REQ-006 Error flag SHALL be set when paddr[1:0]!=0, or when write targets status register (paddr[15]=1 and paddr[3:2]=3).
REQ-007 STROBE: SHALL assert busWrite (write, no error) or busRead (read, no error) for exactly this one cycle; no strobe when error flag set; next CAPTURE for non-error read, else RESP.
REQ-008 CAPTURE: SHALL register {24'b0, busDataOut} into prdata at end of cycle; next RESP.
REQ-009 RESP: SHALL drive pready=1 and pslverr=error flag for exactly one cycle; next IDLE.
REQ-010 Latency SHALL be: non-error write pready in 2nd cycle after setup (setup+2 wait-free access = 3 cycles total); read 4 cycles total; error transfer 3 cycles.
REQ-011 pready SHALL be 0 in all states except RESP; pslverr SHALL be 0 whenever pready=0.
REQ-012 prdata SHALL hold last captured value until next successful read; error reads SHALL leave prdata unchanged.
REQ-013 busAddr and busDataIn SHALL change only on setup latch in IDLE; held stable through STROBE.
REQ-014 busWrite and busRead SHALL never be asserted together and never for more than one consecutive cycle.
REQ-015 penable=1 while in IDLE without prior setup SHALL be ignored (no strobe, no pready).
REQ-016 psel deasserted in STROBE, CAPTURE or RESP SHALL return FSM to IDLE next cycle without pready; a strobe already issued is not reverted.
REQ-017 Back-to-back transfers: setup presented in cycle after RESP SHALL be accepted with no extra idle cycle.
REQ-018 SHALL not interpret buffer/register semantics beyond REQ-006; reads of any address forwarded unchanged.

Reset
REQ-019 With busResetn=0 at a rising edge: FSM=IDLE, prdata=0, pready=0, pslverr=0, busWrite=0, busRead=0, busAddr=0, busDataIn=0, error flag=0.
REQ-020 Reset asserted mid-transfer SHALL abort it: no further strobe, no pready; first setup after busResetn=1 accepted normally.

Verification
REQ-021 Write paddr=0x0010, pwdata=0xA5 -> busAddr=4, busDataIn=0xA5, busWrite=1 one cycle, pready=1 pslverr=0 on 3rd cycle.
REQ-022 Read paddr=0x8008 with model returning 0x1F -> busRead=1 one cycle, prdata=0x0000001F with pready=1 on 4th cycle.
REQ-023 Write paddr=0x800C (status) and write paddr=0x0011 -> no busWrite, pready=1 pslverr=1 on 3rd cycle; prdata unchanged.
REQ-024 Three back-to-back writes to 0x0,0x4,0x8 -> three single-cycle busWrite pulses, addresses 0,1,2, no idle cycle between RESP and next setup.
REQ-025 busResetn=0 during CAPTURE of a read -> outputs at reset values next cycle, no pready; following write completes per REQ-021.
